system_ctl: RTL

- Parametrised successor to the system command handler.
- Sits on the command dispatcher bus. Serves GET_VERSION with a configurable number of capability words, GET_TIME, SYNC_TIME with a configurable latch delay, and SHUTDOWN.
- Adds a masked, sticky NFAULT-wide fault register with timestamped involuntary shutdown reports, plus SET_FAULT_MASK and CLEAR_FAULT commands to leave shutdown.

---
 rtl/system_ctl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/system_ctl.sv
// System command handler: version/capabilities, time get/sync, shutdown, and a masked
// sticky fault register that raises a timestamped involuntary shutdown report.
module system_ctl #(
   parameter int                CMD_BITS           = 6,
   parameter int                CMD_GET_VERSION    = 0,
   parameter int                RSP_GET_VERSION    = 1,
   parameter int                CMD_SYNC_TIME      = 2,
   parameter int                CMD_GET_TIME       = 3,
   parameter int                RSP_GET_TIME       = 4,
   parameter int                CMD_SHUTDOWN       = 5,
   parameter int                RSP_SHUTDOWN       = 6,
   parameter int                CMD_SET_FAULT_MASK = 7,
   parameter int                CMD_CLEAR_FAULT    = 8,
   parameter logic [31:0]       VERSION            = 32'd0,
   parameter int                NCAPS              = 2,
   parameter int                NFAULT             = 8,
   parameter logic [NFAULT-1:0] FAULT_MASK_RESET   = '1,
   parameter logic [63:0]       SYNC_DELAY         = 64'd4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [63:0]           time_in,
   input  logic [31:0]           arg_data,
   output logic                  arg_advance,
   input  logic [CMD_BITS-1:0]   cmd,
   input  logic                  cmd_ready,
   output logic                  cmd_done,
   output logic [31:0]           param_data,
   output logic                  param_write,
   output logic                  invol_req,
   input  logic                  invol_grant,
   output logic [63:0]           time_out,
   output logic                  time_out_en,
   input  logic                  timesync_latch_in,
   input  logic [32*NCAPS-1:0]   caps,
   input  logic [NFAULT-1:0]     fault_in,
   output logic [NFAULT-1:0]     fault_mask,
   output logic                  shutdown
);

   localparam logic [CMD_BITS-1:0] C_VER  = CMD_BITS'(CMD_GET_VERSION);
   localparam logic [CMD_BITS-1:0] C_SYNC = CMD_BITS'(CMD_SYNC_TIME);
   localparam logic [CMD_BITS-1:0] C_GT   = CMD_BITS'(CMD_GET_TIME);
   localparam logic [CMD_BITS-1:0] C_SHUT = CMD_BITS'(CMD_SHUTDOWN);
   localparam logic [CMD_BITS-1:0] C_MASK = CMD_BITS'(CMD_SET_FAULT_MASK);
   localparam logic [CMD_BITS-1:0] C_CLR  = CMD_BITS'(CMD_CLEAR_FAULT);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_VER, S_TIME, S_SYNC, S_REP, S_RSP
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        idx;
   logic              ret, from_rep, reported;
   logic [31:0]       rsp_code, arg_lo, ver_word, rep_word;
   logic [63:0]       time_snap, fault_time, latched_time;
   logic [NFAULT-1:0] sticky, sticky_nxt, fault_hit;
   logic              ts_s1, ts_s2, ts_prev;
   logic              known, accept_ok, take, grant_take, invol_start, clear_take;

   assign arg_advance = 1'b1;
   assign fault_hit   = fault_in & fault_mask;
   assign sticky_nxt  = sticky | fault_hit;

   assign known = (cmd == C_VER) || (cmd == C_SYNC) || (cmd == C_GT) ||
                  (cmd == C_SHUT) || (cmd == C_MASK) || (cmd == C_CLR);
   assign accept_ok   = (state == S_IDLE) || (state == S_WAIT);
   assign take        = accept_ok && cmd_ready && known;
   // A command in the same cycle as a grant wins; the arbiter keeps granting.
   assign grant_take  = (state == S_WAIT) && invol_grant && !cmd_ready;
   assign invol_start = (state == S_IDLE) && !cmd_ready && (sticky != '0) && !reported;
   assign clear_take  = take && (cmd == C_CLR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_WAIT: begin
            if (take) begin
               if (cmd == C_VER)       state_nxt = S_VER;
               else if (cmd == C_GT)   state_nxt = S_TIME;
               else if (cmd == C_SYNC) state_nxt = S_SYNC;
               else                    state_nxt = S_RSP;
            end else if (invol_start) begin
               state_nxt = S_WAIT;
            end else if (grant_take) begin
               state_nxt = S_REP;
            end
         end
         S_VER:          if (idx == 4'(NCAPS)) state_nxt = S_RSP;
         S_TIME:         if (idx == 4'd1) state_nxt = S_RSP;
         S_REP:          if (idx == 4'd2) state_nxt = S_RSP;
         S_SYNC, S_RSP:  state_nxt = ret ? S_WAIT : S_IDLE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ver_word = VERSION;
      for (int i = 0; i < NCAPS; i++) begin
         if (idx == 4'(i + 1)) ver_word = caps[32*i +: 32];
      end
   end

   always_comb begin
      case (idx)
         4'd0:    rep_word = 32'(sticky);
         4'd1:    rep_word = fault_time[31:0];
         default: rep_word = fault_time[63:32];
      endcase
   end

   always_comb begin
      param_write = 1'b0;
      param_data  = '0;
      cmd_done    = 1'b0;
      time_out_en = 1'b0;
      time_out    = '0;
      case (state)
         S_VER: begin
            param_write = 1'b1;
            param_data  = ver_word;
         end
         S_TIME: begin
            param_write = 1'b1;
            param_data  = (idx == 4'd0) ? time_snap[31:0] : time_snap[63:32];
         end
         S_REP: begin
            param_write = 1'b1;
            param_data  = rep_word;
         end
         S_SYNC: begin
            // arg_data now carries the high word; the low word was captured at accept.
            time_out_en = 1'b1;
            cmd_done    = 1'b1;
            time_out    = time_in - latched_time + {arg_data, arg_lo} + SYNC_DELAY;
         end
         S_RSP: begin
            cmd_done   = 1'b1;
            param_data = rsp_code;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         ret       <= 1'b0;
         from_rep  <= 1'b0;
         rsp_code  <= '0;
         arg_lo    <= '0;
         time_snap <= '0;
         invol_req <= 1'b0;
      end else begin
         if (state_nxt == state && (state == S_VER || state == S_TIME || state == S_REP))
            idx <= idx + 4'd1;
         else
            idx <= '0;
         if (take) begin
            ret       <= (state == S_WAIT);
            from_rep  <= 1'b0;
            time_snap <= time_in;
            arg_lo    <= arg_data;
            if (cmd == C_VER)     rsp_code <= 32'(RSP_GET_VERSION);
            else if (cmd == C_GT) rsp_code <= 32'(RSP_GET_TIME);
            else                  rsp_code <= '0;
         end else if (grant_take) begin
            ret       <= 1'b0;
            from_rep  <= 1'b1;
            rsp_code  <= 32'(RSP_SHUTDOWN);
            invol_req <= 1'b0;
         end else if (invol_start) begin
            invol_req <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_mask <= FAULT_MASK_RESET;
         sticky     <= '0;
         fault_time <= '0;
         reported   <= 1'b0;
         shutdown   <= 1'b0;
      end else begin
         if (clear_take) begin
            sticky   <= '0;
            reported <= 1'b0;
            if (fault_hit == '0) shutdown <= 1'b0;
         end else begin
            sticky <= sticky_nxt;
            if (sticky == '0 && sticky_nxt != '0) fault_time <= time_in;
            if ((take && cmd == C_SHUT) || (state == S_RSP && from_rep)) begin
               shutdown <= 1'b1;
               reported <= 1'b1;
            end
         end
         if (take && cmd == C_MASK) fault_mask <= arg_data[NFAULT-1:0];
      end
   end

   // Falling edge of the synchronised timesync pulse captures the local time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_s1        <= 1'b0;
         ts_s2        <= 1'b0;
         ts_prev      <= 1'b0;
         latched_time <= '0;
      end else begin
         ts_s1   <= timesync_latch_in;
         ts_s2   <= ts_s1;
         ts_prev <= ts_s2;
         if (ts_prev && !ts_s2) latched_time <= time_in;
      end
   end

endmodule
